// File: rtl/demux_array_buffered.sv
// Steers one input word per handshake to port A (sel=1) or port B (sel=0).
// Each port drains through its own show-ahead FIFO with valid/ready.
module demux_array_buffered #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sel,
  input  logic [SIZE-1:0]        in_data,
  output logic                   a_valid,
  input  logic                   a_ready,
  output logic [SIZE-1:0]        a_data,
  output logic                   b_valid,
  input  logic                   b_ready,
  output logic [SIZE-1:0]        b_data,
  output logic [$clog2(DEPTH):0] a_count,
  output logic [$clog2(DEPTH):0] b_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [SIZE-1:0] r_mem_a [DEPTH];
  logic [SIZE-1:0] r_mem_b [DEPTH];
  logic [PW-1:0]   r_wptr_a;
  logic [PW-1:0]   r_rptr_a;
  logic [PW-1:0]   r_wptr_b;
  logic [PW-1:0]   r_rptr_b;
  logic [CW-1:0]   r_count_a;
  logic [CW-1:0]   r_count_b;

  logic w_full_a;
  logic w_full_b;
  logic w_push_a;
  logic w_push_b;
  logic w_pop_a;
  logic w_pop_b;

  // Readiness looks only at the selected FIFO, never at the sink handshakes.
  assign w_full_a = (r_count_a == CW'(DEPTH));
  assign w_full_b = (r_count_b == CW'(DEPTH));
  assign in_ready = sel ? !w_full_a : !w_full_b;

  assign w_push_a = in_valid && sel && !w_full_a;
  assign w_push_b = in_valid && !sel && !w_full_b;

  assign a_valid  = (r_count_a != '0);
  assign b_valid  = (r_count_b != '0);
  assign w_pop_a  = a_valid && a_ready;
  assign w_pop_b  = b_valid && b_ready;

  // Head word shown while valid, zero otherwise.
  assign a_data   = a_valid ? r_mem_a[r_rptr_a] : '0;
  assign b_data   = b_valid ? r_mem_b[r_rptr_b] : '0;
  assign a_count  = r_count_a;
  assign b_count  = r_count_b;

  // Storage needs no reset: contents are unobservable until a push makes them valid.
  always_ff @(posedge clk) begin
    if (w_push_a) begin
      r_mem_a[r_wptr_a] <= in_data;
    end
    if (w_push_b) begin
      r_mem_b[r_wptr_b] <= in_data;
    end
  end

  // Port A pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr_a  <= '0;
      r_rptr_a  <= '0;
      r_count_a <= '0;
    end else begin
      if (w_push_a) begin
        r_wptr_a <= r_wptr_a + PW'(1);
      end
      if (w_pop_a) begin
        r_rptr_a <= r_rptr_a + PW'(1);
      end
      case ({w_push_a, w_pop_a})
        2'b10:   r_count_a <= r_count_a + CW'(1);
        2'b01:   r_count_a <= r_count_a - CW'(1);
        default: r_count_a <= r_count_a;
      endcase
    end
  end

  // Port B pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr_b  <= '0;
      r_rptr_b  <= '0;
      r_count_b <= '0;
    end else begin
      if (w_push_b) begin
        r_wptr_b <= r_wptr_b + PW'(1);
      end
      if (w_pop_b) begin
        r_rptr_b <= r_rptr_b + PW'(1);
      end
      case ({w_push_b, w_pop_b})
        2'b10:   r_count_b <= r_count_b + CW'(1);
        2'b01:   r_count_b <= r_count_b - CW'(1);
        default: r_count_b <= r_count_b;
      endcase
    end
  end

endmodule
